// File: rtl/wb_ram_tester_pkg.sv
// wb_ram_tester_pkg
// Shared types and constants for the Wishbone RAM tester:
//   state_t      - tester FSM states
//   WB_SEL_ALL   - byte-select value for full 32-bit transfers
//   ERR_SAT      - saturation value of the mismatch counter
//   WORD_STRIDE  - byte distance between consecutive test words
//   pattern_word - expected data for word idx of a seeded test
package wb_ram_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_WR_GAP = 3'd2,
    ST_RD     = 3'd3,
    ST_RD_GAP = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  localparam logic [3:0]  WB_SEL_ALL   = 4'hF;
  localparam logic [15:0] ERR_SAT      = 16'hFFFF;
  localparam int          WORD_STRIDE  = 4;
  localparam int          STRIDE_SHIFT = $clog2(WORD_STRIDE);

  // Incrementing pattern; wraps modulo 2^32.
  function automatic logic [31:0] pattern_word(input logic [31:0] seed,
                                               input logic [15:0] idx);
    return seed + {16'd0, idx};
  endfunction

endpackage

// File: rtl/wb_ram_tester_timeout.sv
// wb_ram_tester_timeout
// Loadable 8-bit down-counter bounding how long one Wishbone transfer may
// wait for ack/err. Loaded as the strobe rises, counts while the strobe is
// held, and flags expiry once it reaches zero (it never underflows).
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   load       - reload counter with load_val (has priority over en)
//   en         - count down by one this cycle
//   load_val   - reload value
//   expired    - registered flag: counter is zero
module wb_ram_tester_timeout (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_val,
  output logic       expired
);

  logic [7:0] cnt_r;
  logic       expired_r;

  // Down-counter with registered expiry flag tracking the next count value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= 8'd0;
      expired_r <= 1'b1;
    end else if (load) begin
      cnt_r     <= load_val;
      expired_r <= (load_val == 8'd0);
    end else if (en && (cnt_r != 8'd0)) begin
      cnt_r     <= cnt_r - 8'd1;
      expired_r <= (cnt_r == 8'd1);
    end
  end

  assign expired = expired_r;

endmodule

// File: rtl/wb_ram_tester.sv
// wb_ram_tester
// Wishbone classic initiator that writes a seeded incrementing pattern over
// num_words words starting at base_addr, reads it back and reports the
// outcome. Each transfer is an isolated single cycle followed by one idle
// gap cycle. A bus error or a transfer timeout aborts the test.
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   start, base_addr, num_words,   - test request and its parameters
//   seed                             (sampled only when not busy)
//   busy, done                     - test running / 1-cycle end pulse
//   pass, aborted                  - result, valid from done to next start
//   err_count, first_fail_addr     - saturating mismatch count, first bad addr
//   wb_*                           - Wishbone classic master port
module wb_ram_tester
  import wb_ram_tester_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [15:0]   num_words,
  input  logic [31:0]   seed,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          aborted,
  output logic [15:0]   err_count,
  output logic [AW-1:0] first_fail_addr,
  output logic [AW-1:0] wb_adr_o,
  output logic [31:0]   wb_dat_o,
  input  logic [31:0]   wb_dat_i,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  // The counter runs one cycle per held strobe cycle, so loading TIMEOUT-1
  // makes it expire during the TIMEOUT-th strobe cycle.
  localparam logic [7:0]    TMO_LOAD   = 8'(TIMEOUT - 1);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(2'b11);

  state_t        state_r;
  logic          start_r;
  logic [AW-1:0] base_r;
  logic [15:0]   num_r;
  logic [31:0]   seed_r;
  logic [15:0]   idx_r;

  logic          last_s;
  logic [15:0]   idx_next_s;
  logic [AW-1:0] adr_next_s;
  logic [31:0]   dat_next_s;
  logic          abort_s;
  logic          mismatch_s;
  logic          tmo_load_s;
  logic          tmo_en_s;
  logic          tmo_expired_s;

  // Accept start only while idle; the control inputs are frozen with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_r <= 1'b0;
      base_r  <= '0;
      num_r   <= 16'd0;
      seed_r  <= 32'd0;
    end else if (start && !busy && !start_r) begin
      start_r <= 1'b1;
      base_r  <= base_addr & ALIGN_MASK;
      num_r   <= num_words;
      seed_r  <= seed;
    end else begin
      start_r <= 1'b0;
    end
  end

  // Next-word address/data, abort detection and timeout control.
  always_comb begin
    last_s     = (idx_r == (num_r - 16'd1));
    idx_next_s = idx_r + 16'd1;
    adr_next_s = base_r + (AW'(idx_next_s) << STRIDE_SHIFT);
    dat_next_s = pattern_word(seed_r, idx_next_s);
    // err wins over a simultaneous ack; ack wins over an expiring timer.
    abort_s    = wb_err_i | (~wb_ack_i & tmo_expired_s);
    mismatch_s = (wb_dat_i != wb_dat_o);
    tmo_en_s   = (state_r == ST_WR) || (state_r == ST_RD);
    tmo_load_s = ((state_r == ST_IDLE) && start_r && (num_r != 16'd0)) ||
                 (state_r == ST_WR_GAP) ||
                 ((state_r == ST_RD_GAP) && !last_s);
  end

  wb_ram_tester_timeout u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (tmo_load_s),
    .en       (tmo_en_s),
    .load_val (TMO_LOAD),
    .expired  (tmo_expired_s)
  );

  // Tester FSM with all status and bus outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      idx_r           <= 16'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      aborted         <= 1'b0;
      err_count       <= 16'd0;
      first_fail_addr <= '0;
      wb_adr_o        <= '0;
      wb_dat_o        <= 32'd0;
      wb_sel_o        <= 4'd0;
      wb_we_o         <= 1'b0;
      wb_cyc_o        <= 1'b0;
      wb_stb_o        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_r) begin
            idx_r           <= 16'd0;
            err_count       <= 16'd0;
            first_fail_addr <= '0;
            aborted         <= 1'b0;
            if (num_r == 16'd0) begin
              pass    <= 1'b1;
              done    <= 1'b1;
              state_r <= ST_FINISH;
            end else begin
              pass     <= 1'b0;
              busy     <= 1'b1;
              wb_adr_o <= base_r;
              wb_dat_o <= seed_r;
              wb_sel_o <= WB_SEL_ALL;
              wb_we_o  <= 1'b1;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              state_r  <= ST_WR;
            end
          end
        end

        ST_WR, ST_RD: begin
          if (abort_s) begin
            aborted  <= 1'b1;
            pass     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state_r  <= ST_FINISH;
          end else if (wb_ack_i) begin
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (state_r == ST_RD) begin
              if (mismatch_s) begin
                if (err_count != ERR_SAT) begin
                  err_count <= err_count + 16'd1;
                end
                // A saturating counter never returns to zero, so zero
                // identifies the first mismatch of this test.
                if (err_count == 16'd0) begin
                  first_fail_addr <= wb_adr_o;
                end
              end
              state_r <= ST_RD_GAP;
            end else begin
              state_r <= ST_WR_GAP;
            end
          end
        end

        ST_WR_GAP: begin
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          if (last_s) begin
            // Write phase complete: restart from word 0 for the read-back.
            idx_r    <= 16'd0;
            wb_adr_o <= base_r;
            wb_dat_o <= seed_r;
            wb_we_o  <= 1'b0;
            state_r  <= ST_RD;
          end else begin
            idx_r    <= idx_next_s;
            wb_adr_o <= adr_next_s;
            wb_dat_o <= dat_next_s;
            wb_we_o  <= 1'b1;
            state_r  <= ST_WR;
          end
        end

        ST_RD_GAP: begin
          if (last_s) begin
            idx_r   <= 16'd0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_count == 16'd0) && !aborted;
            state_r <= ST_FINISH;
          end else begin
            idx_r    <= idx_next_s;
            wb_adr_o <= adr_next_s;
            wb_dat_o <= dat_next_s;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state_r  <= ST_RD;
          end
        end

        ST_FINISH: begin
          state_r <= ST_IDLE;
        end

        default: begin
          busy     <= 1'b0;
          wb_we_o  <= 1'b0;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_tester.sv
// tb_wb_ram_tester
// Directed bench for wb_ram_tester with a small Wishbone RAM responder whose
// ack latency, read corruption, write error and ack suppression are steered
// from the stimulus sequence.
module tb_wb_ram_tester;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   num_words = 16'd0;
  logic [31:0]   seed = 32'd0;
  logic          busy, done, pass, aborted;
  logic [15:0]   err_count;
  logic [AW-1:0] first_fail_addr;
  logic [AW-1:0] wb_adr_o;
  logic [31:0]   wb_dat_o, wb_dat_i;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;

  always #5 clk = ~clk;

  wb_ram_tester #(.AW(AW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .seed(seed), .busy(busy), .done(done),
    .pass(pass), .aborted(aborted), .err_count(err_count),
    .first_fail_addr(first_fail_addr), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  int checks = 0;
  int errors = 0;

  // Responder controls.
  int          ack_dly    = 0;
  logic        no_ack     = 1'b0;
  int          err_wr_idx = -1;
  logic [15:0] corrupt    = 16'h0000;
  logic        clr_log    = 1'b0;

  // Responder state and transfer log.
  logic [31:0] mem [16];
  logic [31:0] wr_adr [16];
  logic [31:0] wr_dat [16];
  int          wcnt = 0, wr_n = 0, rd_n = 0, stb_n = 0;
  logic        cyc_seen = 1'b0;
  logic [3:0]  widx;
  logic        bus_req;

  assign widx     = wb_adr_o[5:2];
  assign bus_req  = wb_cyc_o & wb_stb_o;
  assign wb_err_i = bus_req & wb_we_o & (wr_n == err_wr_idx);
  assign wb_ack_i = bus_req & ~wb_err_i & ~no_ack & (wcnt == ack_dly);
  assign wb_dat_i = corrupt[widx] ? 32'h0000_0000 : mem[widx];

  // RAM responder: stores writes, logs transfers, counts wait cycles.
  always @(posedge clk) begin
    if (clr_log) begin
      wr_n     <= 0;
      rd_n     <= 0;
      stb_n    <= 0;
      cyc_seen <= 1'b0;
    end else begin
      if (wb_cyc_o) cyc_seen <= 1'b1;
      if (bus_req) stb_n <= stb_n + 1;
      if (wb_ack_i && wb_we_o) begin
        mem[widx] <= wb_dat_o;
        if (wr_n < 16) begin
          wr_adr[wr_n] <= wb_adr_o;
          wr_dat[wr_n] <= wb_dat_o;
        end
        wr_n <= wr_n + 1;
      end
      if (wb_ack_i && !wb_we_o) rd_n <= rd_n + 1;
    end
    if (bus_req && !wb_ack_i && !wb_err_i) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge right after the
  // edge that sampled start (edge 0).
  task automatic do_start(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s);
    @(negedge clk);
    base_addr = b;
    num_words = n;
    seed      = s;
    start     = 1'b1;
    clr_log   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    clr_log = 1'b0;
  endtask

  // Counts edges after edge 0 until done is seen; gives up after 200.
  task automatic wait_done(input int first, output int e);
    e = first;
    do begin
      @(negedge clk);
      e++;
    end while (!done && e < 200);
  endtask

  int e;
  logic found;

  initial begin
    // Reset state.
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_sel", wb_sel_o, 4'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_errcnt", err_count, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic pass: 4 words at 0x100, 1st-cycle ack -> 2 edges per word.
    ack_dly = 0;
    do_start(32'h0000_0100, 16'd4, 32'hA5A5_0000);
    chk("t1_busy_edge0", busy, 1'b0);
    @(negedge clk);
    chk("t1_busy_edge1", busy, 1'b1);
    chk("t1_cyc_edge1", wb_cyc_o, 1'b1);
    chk("t1_stb_edge1", wb_stb_o, 1'b1);
    chk("t1_we_edge1", wb_we_o, 1'b1);
    chk("t1_sel_edge1", wb_sel_o, 4'hF);
    chk("t1_adr_edge1", wb_adr_o, 32'h0000_0100);
    wait_done(1, e);
    chk("t1_done_edge", e, 32'd17);
    chk("t1_pass", pass, 1'b1);
    chk("t1_busy_at_done", busy, 1'b0);
    chk("t1_aborted", aborted, 1'b0);
    chk("t1_errcnt", err_count, 16'd0);
    chk("t1_wr_n", wr_n, 32'd4);
    chk("t1_rd_n", rd_n, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_wr_adr%0d", i), wr_adr[i], 32'h0000_0100 + 32'(4 * i));
      chk($sformatf("t1_wr_dat%0d", i), wr_dat[i], 32'hA5A5_0000 + 32'(i));
    end
    @(negedge clk);
    chk("t1_done_pulse", done, 1'b0);
    chk("t1_pass_held", pass, 1'b1);

    // Zero words: done one edge after edge 0, no bus activity.
    do_start(32'h0000_0200, 16'd0, 32'h1111_1111);
    wait_done(0, e);
    chk("t2_done_edge", e, 32'd1);
    chk("t2_pass", pass, 1'b1);
    chk("t2_cyc_seen", cyc_seen, 1'b0);

    // Corrupt word at 0x108, ack after 2 waits -> 4 edges per word.
    corrupt = 16'h0004;
    ack_dly = 2;
    do_start(32'h0000_0100, 16'd4, 32'hA5A5_0000);
    wait_done(0, e);
    chk("t3_done_edge", e, 32'd33);
    chk("t3_errcnt", err_count, 16'd1);
    chk("t3_ffa", first_fail_addr, 32'h0000_0108);
    chk("t3_pass", pass, 1'b0);
    chk("t3_aborted", aborted, 1'b0);

    // Corrupt all four words.
    corrupt = 16'h000F;
    ack_dly = 0;
    do_start(32'h0000_0100, 16'd4, 32'hA5A5_0000);
    wait_done(0, e);
    chk("t4_errcnt", err_count, 16'd4);
    chk("t4_ffa", first_fail_addr, 32'h0000_0100);
    chk("t4_pass", pass, 1'b0);
    corrupt = 16'h0000;

    // Bus error on the second write.
    err_wr_idx = 1;
    do_start(32'h0000_0100, 16'd4, 32'hA5A5_0000);
    wait_done(0, e);
    chk("t5_done_edge", e, 32'd4);
    chk("t5_aborted", aborted, 1'b1);
    chk("t5_pass", pass, 1'b0);
    chk("t5_cyc_idle", wb_cyc_o, 1'b0);
    chk("t5_wr_n", wr_n, 32'd1);
    chk("t5_rd_n", rd_n, 32'd0);
    err_wr_idx = -1;

    // Never ack: abort after 8 strobe cycles.
    no_ack = 1'b1;
    do_start(32'h0000_0100, 16'd4, 32'hA5A5_0000);
    wait_done(0, e);
    chk("t6_done_edge", e, 32'd9);
    chk("t6_aborted", aborted, 1'b1);
    chk("t6_stb_cycles", stb_n, 32'd8);
    chk("t6_pass", pass, 1'b0);
    no_ack = 1'b0;

    // Stray start while busy is ignored.
    do_start(32'h0000_0100, 16'd2, 32'h1234_0000);
    @(negedge clk);
    @(negedge clk);
    base_addr = 32'h0000_0000;
    num_words = 16'd8;
    seed      = 32'hDEAD_0000;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t7_done_unaffected", done, 1'b0);
    wait_done(3, e);
    chk("t7_done_edge", e, 32'd9);
    chk("t7_wr_n", wr_n, 32'd2);
    chk("t7_wr_adr1", wr_adr[1], 32'h0000_0104);
    chk("t7_wr_dat1", wr_dat[1], 32'h1234_0001);
    chk("t7_pass", pass, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t7_no_restart", busy, 1'b0);

    // Pattern wraps modulo 2^32.
    do_start(32'h0000_0000, 16'd2, 32'hFFFF_FFFF);
    wait_done(0, e);
    chk("t8_wr_dat0", wr_dat[0], 32'hFFFF_FFFF);
    chk("t8_wr_dat1", wr_dat[1], 32'h0000_0000);
    chk("t8_pass", pass, 1'b1);

    // Asynchronous reset in the middle of the read phase.
    ack_dly = 2;
    do_start(32'h0000_0100, 16'd4, 32'hA5A5_0000);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (wb_cyc_o && wb_stb_o && !wb_we_o) found = 1'b1;
    end
    chk("t9_rd_reached", found, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("t9_cyc", wb_cyc_o, 1'b0);
    chk("t9_stb", wb_stb_o, 1'b0);
    chk("t9_we", wb_we_o, 1'b0);
    chk("t9_busy", busy, 1'b0);
    chk("t9_adr", wb_adr_o, 32'h0);
    chk("t9_dat", wb_dat_o, 32'h0);
    chk("t9_sel", wb_sel_o, 4'h0);
    chk("t9_errcnt", err_count, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t9_idle_after", wb_cyc_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
